// File: rtl/mul_coef_arbiter.sv
// mul_coef_arbiter: two clients share one shift-add multiplier and one
// locally loaded coefficient table. An idle engine accepts one request
// (round-robin on ties), fetches the coefficient, then multiplies one
// coefficient bit per cycle and posts a single-cycle response pulse.
module mul_coef_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  req0_valid,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_op,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_op,
  output logic                  req1_ready,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [2*DATA_W-1:0]   rsp_prod,
  output logic                  busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   table_q [DEPTH];

  // prio_q is the requester that wins when both are valid, i.e. the one
  // not served last. Reset value 0 lets req0 win the first tie.
  logic                prio_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   op_q;
  logic                id_q;
  logic [DATA_W-1:0]   coef_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   mcand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [PROD_W-1:0]   rsp_prod_q;
  logic                busy_q;

  logic                grant_vld_d;
  logic                grant_id_d;
  logic                accept_d;
  logic [PROD_W-1:0]   acc_d;

  // Pick the requester to grant: a lone valid wins outright, a tie goes to prio_q.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_d = 1'b1;
      grant_id_d  = prio_q;
    end else if (req0_valid) begin
      grant_vld_d = 1'b1;
      grant_id_d  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_d = 1'b1;
      grant_id_d  = 1'b1;
    end else begin
      grant_vld_d = 1'b0;
      grant_id_d  = 1'b0;
    end
  end

  // Ready is offered only from IDLE and never while reset is asserted.
  assign accept_d   = rst && (state_q == S_IDLE) && grant_vld_d;
  assign req0_ready = accept_d && !grant_id_d;
  assign req1_ready = accept_d && grant_id_d;

  // Partial-product accumulate for the coefficient bit selected by the counter.
  always_comb begin
    acc_d = acc_q;
    if (coef_q[cnt_q]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Coefficient table: cleared by reset, otherwise written whenever cfg_we is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_we) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // Engine FSM: accept, fetch coefficient, shift-add DATA_W bits, post response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      addr_q      <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      coef_q      <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_prod_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            addr_q  <= grant_id_d ? req1_addr : req0_addr;
            op_q    <= grant_id_d ? req1_op : req0_op;
            id_q    <= grant_id_d;
            prio_q  <= ~grant_id_d;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Reads the table value from before any same-cycle cfg write.
          coef_q  <= table_q[addr_q];
          acc_q   <= '0;
          mcand_q <= {{DATA_W{1'b0}}, op_q};
          cnt_q   <= '0;
          state_q <= S_MUL;
        end
        S_MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            rsp_prod_q  <= acc_d;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_coef_arbiter.sv
// Bench for mul_coef_arbiter: directed vectors, hand-written multi-cycle
// sequences and random traffic, all compared every cycle against a
// timeline model (acceptance time + fixed offsets, table as an array).
module tb_mul_coef_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [DW-1:0]   cfg_data;
  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [DW-1:0]   req0_op;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [DW-1:0]   req1_op;
  logic            req1_ready;
  logic            rsp_valid;
  logic            rsp_id;
  logic [2*DW-1:0] rsp_prod;
  logic            busy;

  always #5 clk = ~clk;

  mul_coef_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_prod   (rsp_prod),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model state
  int  mtbl [256];
  bit  m_infl;
  int  m_acc_t;
  bit  m_id;
  int  m_addr;
  int  m_op;
  int  m_pend;
  int  m_last;
  int  m_rsp_prod;
  int  m_rsp_id;

  // Per-step observations
  bit  acc_now;
  bit  acc_id;
  bit  rsp_now;
  int  cap_prod;
  int  cap_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mtbl[i]) mtbl[i] = 0;
    m_infl     = 1'b0;
    m_last     = 1;
    m_rsp_prod = 0;
    m_rsp_id   = 0;
  endtask

  // One clock cycle: inputs already driven by the caller at the negedge.
  task automatic step();
    bit e_r0, e_r1, e_rv, e_busy;
    acc_now = 1'b0;
    rsp_now = 1'b0;
    #1;
    if (rst !== 1'b1) begin
      chk("ready0_in_reset", req0_ready, 0);
      chk("ready1_in_reset", req1_ready, 0);
      model_reset();
    end else begin
      if (m_infl && cyc > m_acc_t + 10) m_infl = 1'b0;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!m_infl) begin
        if (req0_valid && req1_valid) begin
          if (m_last == 0) e_r1 = 1'b1;
          else e_r0 = 1'b1;
        end else if (req0_valid) begin
          e_r0 = 1'b1;
        end else if (req1_valid) begin
          e_r1 = 1'b1;
        end
      end
      if (m_infl && cyc == m_acc_t + 1) m_pend = mtbl[m_addr] * m_op;
      e_rv   = m_infl && (cyc == m_acc_t + 10);
      e_busy = m_infl && (cyc >= m_acc_t + 1);
      if (e_rv) begin
        m_rsp_prod = m_pend;
        m_rsp_id   = m_id;
      end
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("busy", busy, e_busy);
      chk("rsp_prod", rsp_prod, m_rsp_prod);
      chk("rsp_id", rsp_id, m_rsp_id);
      if (e_r0 || e_r1) begin
        m_infl  = 1'b1;
        m_acc_t = cyc;
        m_id    = e_r1;
        m_addr  = e_r1 ? int'(req1_addr) : int'(req0_addr);
        m_op    = e_r1 ? int'(req1_op) : int'(req0_op);
        m_last  = e_r1 ? 1 : 0;
      end
      acc_now = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      acc_id  = req1_valid && req1_ready;
      if (rsp_valid === 1'b1) begin
        rsp_now  = 1'b1;
        cap_prod = int'(rsp_prod);
        cap_id   = int'(rsp_id);
      end
      if (cfg_we) mtbl[cfg_addr] = int'(cfg_data);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wr_cfg(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = DW'(d);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_now && n < 30);
    chk("accept_seen", acc_now, 1);
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!rsp_now && n < 30);
    chk("rsp_seen", rsp_now, 1);
    lat = n;
  endtask

  task automatic run_one(input bit id, input int addr, input int op,
                         output int prod, output int rid, output int lat);
    prod = -1;
    rid  = -1;
    lat  = -1;
    if (id) begin
      req1_valid = 1'b1; req1_addr = AW'(addr); req1_op = DW'(op);
    end else begin
      req0_valid = 1'b1; req0_addr = AW'(addr); req0_op = DW'(op);
    end
    wait_accept();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (acc_now) begin
      wait_rsp(lat);
      prod = cap_prod;
      rid  = cap_id;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    bit wr;
    int waddr;
    int wdata;
    bit id;
    int addr;
    int op;
    int exp;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   prod, rid, lat, n, k;
    int   ids[4];
    int   prods[4];
    int   nrsp;

    vecs[0] = '{1'b0,   0,   0, 1'b0,   0, 200,     0};
    vecs[1] = '{1'b1,   5,  13, 1'b0,   5,  11,   143};
    vecs[2] = '{1'b1, 255, 255, 1'b1, 255, 255, 65025};
    vecs[3] = '{1'b1,   3,   9, 1'b0,   3,   0,     0};
    vecs[4] = '{1'b1,  20, 100, 1'b1,  20, 100, 10000};
    vecs[5] = '{1'b1, 128,   1, 1'b1, 128, 255,   255};
    vecs[6] = '{1'b1,  64, 128, 1'b0,  64,   2,   256};
    vecs[7] = '{1'b1,  66, 170, 1'b0,  66,  85, 14450};

    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    req0_valid = 1'b0; req0_addr = '0; req0_op = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_op = '0;
    model_reset();
    step();
    step();
    rst = 1'b1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_prod", rsp_prod, 0);
    chk("reset_busy", busy, 0);

    // Directed vectors (vector 0 relies on the freshly cleared table)
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) wr_cfg(vecs[i].waddr, vecs[i].wdata);
      run_one(vecs[i].id, vecs[i].addr, vecs[i].op, prod, rid, lat);
      chk($sformatf("vec%0d_prod", i), prod, vecs[i].exp);
      chk($sformatf("vec%0d_id", i), rid, int'(vecs[i].id));
      chk($sformatf("vec%0d_latency", i), lat, 10);
    end

    // Round robin with both requesters held valid
    pulse_reset();
    wr_cfg(1, 4);
    wr_cfg(2, 5);
    req0_valid = 1'b1; req0_addr = 8'd1; req0_op = 8'd2;
    req1_valid = 1'b1; req1_addr = 8'd2; req1_op = 8'd3;
    for (int i = 0; i < 4; i++) begin
      ids[i] = -1;
      prods[i] = -1;
    end
    n = 0;
    k = 0;
    while (k < 4 && n < 100) begin
      step();
      n++;
      if (rsp_now) begin
        ids[k]   = cap_id;
        prods[k] = cap_prod;
        k++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_rsp_count", k, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_id%0d", i), ids[i], i % 2);
      chk($sformatf("rr_prod%0d", i), prods[i], (i % 2) ? 15 : 8);
    end

    // Reset during the fourth multiply cycle aborts the operation
    wr_cfg(9, 6);
    req0_valid = 1'b1; req0_addr = 8'd9; req0_op = 8'd7;
    wait_accept();
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    pulse_reset();
    nrsp = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_now) nrsp++;
    end
    chk("abort_no_rsp", nrsp, 0);
    chk("abort_rsp_prod", rsp_prod, 0);
    chk("abort_rsp_id", rsp_id, 0);
    chk("abort_busy", busy, 0);
    run_one(1'b0, 9, 7, prod, rid, lat);
    chk("abort_cleared_table", prod, 0);

    // Config write in the fetch cycle is not seen by that fetch
    wr_cfg(7, 2);
    req0_valid = 1'b1; req0_addr = 8'd7; req0_op = 8'd10;
    wait_accept();
    req0_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 8'd7; cfg_data = 8'd3;
    step();
    cfg_we = 1'b0;
    wait_rsp(lat);
    chk("collide_old_coef", cap_prod, 20);
    run_one(1'b0, 7, 10, prod, rid, lat);
    chk("collide_new_coef", prod, 30);

    // Random traffic against the model
    nrsp = 0;
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(300) != 0);
      cfg_we   = ($urandom_range(3) == 0);
      cfg_addr = AW'($urandom_range(7));
      cfg_data = DW'($urandom_range(255));
      if (req0_valid && $urandom_range(15) == 0) begin
        req0_valid = 1'b0;
      end else if (!req0_valid && $urandom_range(2) == 0) begin
        req0_valid = 1'b1;
        req0_addr  = AW'($urandom_range(7));
        req0_op    = DW'($urandom_range(255));
      end
      if (req1_valid && $urandom_range(15) == 0) begin
        req1_valid = 1'b0;
      end else if (!req1_valid && $urandom_range(2) == 0) begin
        req1_valid = 1'b1;
        req1_addr  = AW'($urandom_range(7));
        req1_op    = DW'($urandom_range(255));
      end
      step();
      if (rsp_now) nrsp++;
      if (acc_now) begin
        if (acc_id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
      end
    end
    chk("rand_rsp_seen", (nrsp > 20) ? 1 : 0, 1);

    rst = 1'b1; cfg_we = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
